// File: rtl/smpl_window_queue.sv
// smpl_window_queue
//
// Circular multi-channel sample queue for the equalizer FIR datapath. Every
// accepted sample is stored. Once at least TAPS samples are held, each
// accepted sample starts a readout of the most recent TAPS samples, streamed
// oldest-to-newest, one per cycle.
//
// Ports
//   clk         clock
//   rst_n       asynchronous active-low reset
//   clr         synchronous flush back to the empty FILL state
//   wrt_smpl    one-cycle strobe: smpl_in carries a new sample
//   smpl_in     CHAN*DATA_W, channel k at [k*DATA_W +: DATA_W]
//   smpl_out    registered window sample, same packing
//   smpl_vld    smpl_out holds a window sample this cycle
//   sequencing  read addresses are being issued this cycle
//   full        queue holds at least TAPS samples
//   overrun     sticky: a sample was accepted while a readout was running
//
// Stream semantics: there is no backpressure. wrt_smpl is a pure strobe that
// is accepted (or dropped by decimation/clr) in the cycle it is high. On the
// output side, the consumer must take smpl_out in every cycle that smpl_vld
// is high.
module smpl_window_queue #(
  parameter int DATA_W = 16,
  parameter int CHAN   = 2,
  parameter int DEPTH  = 1536,
  parameter int TAPS   = 1021,
  parameter int DECIM  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   wrt_smpl,
  input  logic [CHAN*DATA_W-1:0] smpl_in,
  output logic [CHAN*DATA_W-1:0] smpl_out,
  output logic                   smpl_vld,
  output logic                   sequencing,
  output logic                   full,
  output logic                   overrun
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(TAPS + 1);
  localparam int CW = $clog2(TAPS);
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

  typedef enum logic [1:0] {ST_FILL, ST_READ, ST_IDLE} state_t;

  state_t          state;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   newest;
  logic [AW-1:0]   rd_addr;
  logic [CW-1:0]   rd_cnt;
  logic [FW-1:0]   fill_cnt;
  logic [DW-1:0]   dec_cnt;
  logic            pending;
  logic            acc;

  // Pointer increment modulo DEPTH (DEPTH need not be a power of two).
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Oldest address of the window that ends at n: (n - (TAPS-1)) mod DEPTH.
  // Computed as n + (DEPTH-TAPS+1) with one conditional subtract, so the
  // intermediate never goes negative.
  function automatic logic [AW-1:0] win_start(input logic [AW-1:0] n);
    logic [AW:0] s;
    s = {1'b0, n} + (AW+1)'(DEPTH - TAPS + 1);
    if (s >= (AW+1)'(DEPTH)) s = s - (AW+1)'(DEPTH);
    return s[AW-1:0];
  endfunction

  // A strobe is accepted only on the first pulse of each decimation group,
  // and never in a flush cycle.
  assign acc  = wrt_smpl && !clr && (dec_cnt == '0);
  assign full = (fill_cnt == FW'(TAPS));

  // Control FSM: pointers, counters, state and the sequencing flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_FILL;
      wr_ptr     <= '0;
      newest     <= '0;
      rd_addr    <= '0;
      rd_cnt     <= '0;
      fill_cnt   <= '0;
      dec_cnt    <= '0;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      sequencing <= 1'b0;
    end else if (clr) begin
      state      <= ST_FILL;
      wr_ptr     <= '0;
      newest     <= '0;
      rd_addr    <= '0;
      rd_cnt     <= '0;
      fill_cnt   <= '0;
      dec_cnt    <= '0;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      sequencing <= 1'b0;
    end else begin
      if (wrt_smpl)
        dec_cnt <= (dec_cnt == DW'(DECIM - 1)) ? '0 : dec_cnt + 1'b1;

      if (acc) begin
        newest <= wr_ptr;
        wr_ptr <= ptr_inc(wr_ptr);
        if (fill_cnt != FW'(TAPS)) fill_cnt <= fill_cnt + 1'b1;
      end

      case (state)
        ST_FILL: begin
          if (acc && (fill_cnt == FW'(TAPS - 1))) begin
            state      <= ST_READ;
            sequencing <= 1'b1;
            rd_addr    <= win_start(wr_ptr);
            rd_cnt     <= '0;
          end
        end
        ST_IDLE: begin
          if (acc) begin
            state      <= ST_READ;
            sequencing <= 1'b1;
            rd_addr    <= win_start(wr_ptr);
            rd_cnt     <= '0;
          end
        end
        ST_READ: begin
          // A write mid-readout lands outside the active window (DEPTH > TAPS)
          // and is queued as a single pending restart.
          if (acc) begin
            pending <= 1'b1;
            overrun <= 1'b1;
          end
          rd_addr <= ptr_inc(rd_addr);
          rd_cnt  <= rd_cnt + 1'b1;
          if (rd_cnt == CW'(TAPS - 1)) begin
            if (pending || acc) begin
              // Restart without a bubble; the window ends at the newest
              // sample, including one accepted in this very cycle.
              rd_addr <= win_start(acc ? wr_ptr : newest);
              rd_cnt  <= '0;
              pending <= 1'b0;
            end else begin
              state      <= ST_IDLE;
              sequencing <= 1'b0;
            end
          end
        end
        default: begin
          state      <= ST_FILL;
          sequencing <= 1'b0;
        end
      endcase
    end
  end

  // A read issued in a READ cycle produces data one cycle later. This is not
  // gated by clr, so the final in-flight read still completes after a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) smpl_vld <= 1'b0;
    else        smpl_vld <= (state == ST_READ);
  end

  // One RAM per channel: single write port, synchronous read into the
  // resettable output register.
  for (genvar k = 0; k < CHAN; k++) begin : g_chan
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (acc) mem[wr_ptr] <= smpl_in[k*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                rd_q <= '0;
      else if (state == ST_READ) rd_q <= mem[rd_addr];
    end

    assign smpl_out[k*DATA_W +: DATA_W] = rd_q;
  end

endmodule

// File: tb/tb_smpl_window_queue.sv
// Directed bench for smpl_window_queue (DEPTH=12, TAPS=8).
// Instance dut_a uses DECIM=1 and instance dut_d uses DECIM=2. use_d selects
// which instance the driver tasks and the checks operate on.
module tb_smpl_window_queue;
  localparam int DATA_W = 16;
  localparam int CHAN   = 2;
  localparam int DEPTH  = 12;
  localparam int TAPS   = 8;

  logic clk;
  logic rst_n;

  logic                   clr_a, wrt_a, vld_a, seq_a, full_a, ovr_a;
  logic [CHAN*DATA_W-1:0] in_a, out_a;
  logic                   clr_d, wrt_d, vld_d, seq_d, full_d, ovr_d;
  logic [CHAN*DATA_W-1:0] in_d, out_d;

  logic        use_d;
  logic [31:0] o_out;
  logic        o_vld, o_seq, o_full, o_ovr;

  int checks;
  int errors;

  smpl_window_queue #(.DATA_W(DATA_W), .CHAN(CHAN), .DEPTH(DEPTH), .TAPS(TAPS), .DECIM(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr_a), .wrt_smpl(wrt_a), .smpl_in(in_a),
    .smpl_out(out_a), .smpl_vld(vld_a), .sequencing(seq_a), .full(full_a), .overrun(ovr_a)
  );

  smpl_window_queue #(.DATA_W(DATA_W), .CHAN(CHAN), .DEPTH(DEPTH), .TAPS(TAPS), .DECIM(2)) dut_d (
    .clk(clk), .rst_n(rst_n), .clr(clr_d), .wrt_smpl(wrt_d), .smpl_in(in_d),
    .smpl_out(out_d), .smpl_vld(vld_d), .sequencing(seq_d), .full(full_d), .overrun(ovr_d)
  );

  assign o_out  = use_d ? out_d  : out_a;
  assign o_vld  = use_d ? vld_d  : vld_a;
  assign o_seq  = use_d ? seq_d  : seq_a;
  assign o_full = use_d ? full_d : full_a;
  assign o_ovr  = use_d ? ovr_d  : ovr_a;

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sample n: left (channel 0) = n, right (channel 1) = n + 100.
  function automatic logic [31:0] smp(input int n);
    logic [15:0] l, r;
    l = 16'(n);
    r = 16'(n + 100);
    return {r, l};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs and samples then sit 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic drive_wr(input int n);
    if (use_d) begin in_d = smp(n); wrt_d = 1'b1; end
    else       begin in_a = smp(n); wrt_a = 1'b1; end
  endtask

  task automatic release_wr();
    wrt_a = 1'b0;
    wrt_d = 1'b0;
  endtask

  // Strobe sample n; afterwards the bench is in cycle T+1.
  task automatic write_smpl(input int n);
    drive_wr(n);
    tick();
    release_wr();
  endtask

  // Writes that must not start a readout, spaced 20 cycles apart.
  task automatic fill_quiet(input int from, input int to, input int stp);
    for (int n = from; n <= to; n += stp) begin
      write_smpl(n);
      tick();
      chk($sformatf("quiet_seq_%0d", n),  32'(o_seq),  32'd0);
      chk($sformatf("quiet_vld_%0d", n),  32'(o_vld),  32'd0);
      chk($sformatf("quiet_full_%0d", n), 32'(o_full), 32'd0);
      repeat (18) tick();
    end
  endtask

  // Expects nwin back-to-back windows starting now (cycle T+1). Window w
  // holds samples fw, fw+stp, ... Optionally strobes sample inj_n at
  // offset inj_at.
  task automatic check_stream(input int nwin, input int f0, input int f1, input int stp,
                              input int inj_at, input int inj_n);
    int total;
    int j, w, k;
    total = nwin * TAPS;
    for (int i = 0; i <= total; i++) begin
      chk($sformatf("seq_%0d_%0d", f0, i), 32'(o_seq), 32'(i < total));
      chk($sformatf("vld_%0d_%0d", f0, i), 32'(o_vld), 32'(i >= 1));
      if (i >= 1) begin
        j = i - 1;
        w = j / TAPS;
        k = j % TAPS;
        chk($sformatf("data_%0d_%0d", f0, i), o_out, smp(((w == 0) ? f0 : f1) + stp * k));
      end
      if (i == inj_at) drive_wr(inj_n);
      else             release_wr();
      tick();
    end
    release_wr();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    use_d  = 1'b0;
    rst_n  = 1'b0;
    clr_a  = 1'b0; wrt_a = 1'b0; in_a = '0;
    clr_d  = 1'b0; wrt_d = 1'b0; in_d = '0;

    // Reset state
    #2;
    chk("rst_out",  o_out,        32'd0);
    chk("rst_vld",  32'(o_vld),   32'd0);
    chk("rst_seq",  32'(o_seq),   32'd0);
    chk("rst_full", 32'(o_full),  32'd0);
    chk("rst_ovr",  32'(o_ovr),   32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Fill: 1..7 stay quiet, 8 produces window 1..8
    fill_quiet(1, 7, 1);
    write_smpl(8);
    check_stream(1, 1, 0, 1, -1, 0);
    chk("fill_full", 32'(o_full), 32'd1);
    repeat (10) tick();

    // Wrap: every sample produces the latest eight, crossing address 11->0
    for (int n = 9; n <= 20; n++) begin
      write_smpl(n);
      check_stream(1, n - 7, 0, 1, -1, 0);
      repeat (10) tick();
    end
    chk("wrap_full", 32'(o_full), 32'd1);
    chk("wrap_ovr",  32'(o_ovr),  32'd0);

    // Overrun: sample 9 on the 3rd READ cycle of window 1..8
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    chk("clr1_full", 32'(o_full), 32'd0);
    repeat (5) tick();
    fill_quiet(1, 7, 1);
    write_smpl(8);
    chk("ovr_before", 32'(o_ovr), 32'd0);
    check_stream(2, 1, 2, 1, 2, 9);
    chk("ovr_after",  32'(o_ovr),  32'd1);
    chk("ovr_full",   32'(o_full), 32'd1);
    repeat (10) tick();

    // Flush: clr with a same-cycle write, mid-readout
    write_smpl(10);
    tick();
    tick();
    clr_a = 1'b1;
    drive_wr(99);
    tick();
    clr_a = 1'b0;
    release_wr();
    chk("flush_seq",  32'(o_seq),  32'd0);
    chk("flush_full", 32'(o_full), 32'd0);
    chk("flush_ovr",  32'(o_ovr),  32'd0);
    tick();
    chk("flush_vld2", 32'(o_vld),  32'd0);
    repeat (10) tick();
    fill_quiet(51, 57, 1);
    write_smpl(58);
    check_stream(1, 51, 0, 1, -1, 0);
    repeat (10) tick();

    // Async reset mid-readout
    write_smpl(59);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out",  o_out,       32'd0);
    chk("arst_vld",  32'(o_vld),  32'd0);
    chk("arst_seq",  32'(o_seq),  32'd0);
    chk("arst_full", 32'(o_full), 32'd0);
    chk("arst_ovr",  32'(o_ovr),  32'd0);
    tick();
    chk("arst_hold_seq", 32'(o_seq), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("arst_noresume_seq_%0d", i), 32'(o_seq), 32'd0);
      chk($sformatf("arst_noresume_vld_%0d", i), 32'(o_vld), 32'd0);
    end
    fill_quiet(1, 7, 1);
    write_smpl(8);
    check_stream(1, 1, 0, 1, -1, 0);
    repeat (10) tick();

    // Decimation (DECIM=2): only odd samples stored; 15 triggers 1,3,..,15
    use_d = 1'b1;
    #1;
    chk("dec_full0", 32'(o_full), 32'd0);
    fill_quiet(1, 14, 1);
    write_smpl(15);
    check_stream(1, 1, 0, 2, -1, 0);
    chk("dec_full", 32'(o_full), 32'd1);
    chk("dec_ovr",  32'(o_ovr),  32'd0);
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
